// File: rtl/bus_drvr_fifo.sv
// bus_drvr_fifo: per-driver input queue feeding one drvrs port of the bus
// generator/arbiter. The driver side pushes packets. The bus side reads a
// show-ahead head and removes it with pop. Self-addressed packets are dropped
// because the bus cannot route them. Overflow, underflow and drop events are
// counted for the checker.
module bus_drvr_fifo #(
    parameter int          PCKG_SZ   = 32,
    parameter int          DEPTH     = 16,
    parameter logic [7:0]  DRVR_ID   = 8'h00,
    parameter logic [7:0]  BROADCAST = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_in,
    input  logic [PCKG_SZ-1:0]         D_in,
    output logic                       full,
    output logic                       pndng,
    output logic [PCKG_SZ-1:0]         D_pop,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    output logic [15:0]                drop_cnt,
    input  logic                       clr_err
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    // Saturating increment for the drop counter: holds at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end else begin
            return val + 16'd1;
        end
    endfunction

    logic [PCKG_SZ-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               overflow_r;
    logic               underflow_r;
    logic [15:0]        drop_cnt_r;

    logic               empty_s;
    logic               full_s;
    logic               self_s;
    logic               eff_pop_s;
    logic               push_acc_s;
    logic               drop_s;
    logic               ovf_evt_s;
    logic               udf_evt_s;

    // Decode this cycle's push/pop events from the registered occupancy.
    always_comb begin
        empty_s    = 1'b0;
        full_s     = 1'b0;
        self_s     = 1'b0;
        eff_pop_s  = 1'b0;
        push_acc_s = 1'b0;
        drop_s     = 1'b0;
        ovf_evt_s  = 1'b0;
        udf_evt_s  = 1'b0;

        empty_s    = (count_r == {CW{1'b0}});
        full_s     = (count_r == DEPTH_C);
        // Broadcast is never treated as self-addressed, even if the IDs match.
        self_s     = (D_in[PCKG_SZ-1 -: 8] == DRVR_ID) && (DRVR_ID != BROADCAST);
        eff_pop_s  = pop && !empty_s;
        // A pop in the same cycle frees a slot, so a push at full still fits.
        push_acc_s = push_in && !self_s && (!full_s || eff_pop_s);
        drop_s     = push_in && !push_acc_s;
        ovf_evt_s  = push_in && !self_s && full_s && !eff_pop_s;
        udf_evt_s  = pop && empty_s;
    end

    // Packet storage. It has no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= D_in;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (eff_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_acc_s, eff_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags and drop counter. A new event wins over clr_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            drop_cnt_r  <= 16'd0;
        end else begin
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (udf_evt_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
            if (drop_s) begin
                drop_cnt_r <= clr_err ? 16'd1 : sat_inc(drop_cnt_r);
            end else if (clr_err) begin
                drop_cnt_r <= 16'd0;
            end
        end
    end

    // Outputs are decoded from registered state only. The head is gated to 0 when empty.
    always_comb begin
        count     = count_r;
        full      = (count_r == DEPTH_C);
        pndng     = (count_r != {CW{1'b0}});
        overflow  = overflow_r;
        underflow = underflow_r;
        drop_cnt  = drop_cnt_r;
        D_pop     = pndng ? mem_r[rd_ptr_r] : {PCKG_SZ{1'b0}};
    end

endmodule
